// File: rtl/instr_fetch.sv
// Fetch stage: owns the architectural PC, keeps one instruction-memory request in flight,
// and presents {pc, instr} to decode over valid/ready. A flush redirects fetch and drops in-flight work.
module instr_fetch #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h0000_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc_next,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] flush_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_data,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_pc,
  output logic [31:0]           if_instr,
  output logic                  misaligned
);

  localparam int unsigned INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

  state_t                 r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]  r_pc, w_pc_nxt;
  logic [DATA_WIDTH-1:0]  r_req_addr, w_req_addr_nxt;
  logic [DATA_WIDTH-1:0]  w_launch_addr;
  logic [INSTR_WIDTH-1:0] r_instr, w_instr_nxt;
  logic                   r_drop, w_drop_nxt;
  logic                   r_misaligned, w_misaligned_nxt;
  logic                   r_req_valid, r_if_valid;
  logic                   w_launch, w_redirect;

  // Next-state logic; w_launch starts a fetch of w_launch_addr, w_redirect restarts at flush_pc
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_req_addr_nxt   = r_req_addr;
    w_instr_nxt      = r_instr;
    w_drop_nxt       = r_drop;
    w_misaligned_nxt = r_misaligned;
    w_launch         = 1'b0;
    w_launch_addr    = r_pc;
    w_redirect       = 1'b0;

    if (flush) begin
      w_pc_nxt         = flush_pc;
      w_misaligned_nxt = 1'b0;
      case (r_state)
        S_REQ: begin
          // An offered request cannot be retracted; its response must be dropped
          w_drop_nxt = 1'b1;
          if (imem_req_ready) w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            w_drop_nxt = 1'b0;
            w_redirect = 1'b1;
          end else begin
            w_drop_nxt = 1'b1;
          end
        end
        default: w_redirect = 1'b1;
      endcase
    end else begin
      case (r_state)
        S_IDLE: w_launch = 1'b1;
        S_REQ: begin
          if (imem_req_ready) w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (r_drop) begin
              w_drop_nxt = 1'b0;
              w_launch   = 1'b1;
            end else begin
              w_instr_nxt      = imem_rsp_data;
              w_misaligned_nxt = 1'b0;
              w_state_nxt      = S_OUT;
            end
          end
        end
        S_OUT: begin
          if (if_ready) begin
            w_pc_nxt      = pc_next;
            w_launch      = 1'b1;
            w_launch_addr = pc_next;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    // A misaligned flush target passes through IDLE so if_valid still drops for a cycle
    if (w_redirect) begin
      if (flush_pc[1:0] != 2'b00) begin
        w_state_nxt = S_IDLE;
      end else begin
        w_state_nxt    = S_REQ;
        w_req_addr_nxt = flush_pc;
      end
    end

    if (w_launch) begin
      if (w_launch_addr[1:0] != 2'b00) begin
        w_state_nxt      = S_OUT;
        w_misaligned_nxt = 1'b1;
        w_instr_nxt      = NOP;
      end else begin
        w_state_nxt      = S_REQ;
        w_req_addr_nxt   = w_launch_addr;
        w_misaligned_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_instr      <= NOP;
      r_drop       <= 1'b0;
      r_misaligned <= 1'b0;
      r_req_valid  <= 1'b0;
      r_if_valid   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_req_addr   <= w_req_addr_nxt;
      r_instr      <= w_instr_nxt;
      r_drop       <= w_drop_nxt;
      r_misaligned <= w_misaligned_nxt;
      r_req_valid  <= (w_state_nxt == S_REQ);
      r_if_valid   <= (w_state_nxt == S_OUT);
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_req_addr;
  assign if_valid       = r_if_valid;
  assign if_pc          = r_pc;
  assign if_instr       = r_instr;
  assign misaligned     = r_misaligned;

endmodule
